// File: rtl/nvdla_sdp_core_input_mux.sv
// SDP core input mux: picks the CACC or MRDMA stream per layer and forwards it via a 2-entry skid.
// Optional build macro SDP_CMUX_PERF_EN adds the output-stall cycle counter.
module nvdla_sdp_core_input_mux #(
  parameter int DW = 256
) (
  input  logic          nvdla_core_clk,
  input  logic          nvdla_core_rstn,
  input  logic          reg2dp_op_en,
  input  logic          reg2dp_flying_mode,
  input  logic          cacc2sdp_valid,
  output logic          cacc2sdp_ready,
  input  logic [DW+1:0] cacc2sdp_pd,
  input  logic          sdp_mrdma2cmux_valid,
  output logic          sdp_mrdma2cmux_ready,
  input  logic [DW+1:0] sdp_mrdma2cmux_pd,
  output logic          sdp_cmux2dp_valid,
  input  logic          sdp_cmux2dp_ready,
  output logic [DW-1:0] sdp_cmux2dp_pd,
  output logic          cmux_done,
  output logic [31:0]   dp2reg_cmux_stall
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]    state_q, state_d;
  logic          sel_src_q, sel_src_d;
  logic [1:0]    occ_q, occ_d;
  logic          wr_ptr_q, rd_ptr_q;
  logic [DW-1:0] ent0_q, ent1_q;
  logic          rdy_q, rdy_d;
  logic          done_q, done_d;

  logic          op_load_s;
  logic          in_valid_s;
  logic [DW-1:0] in_data_s;
  logic          in_layer_end_s;
  logic          push_s;
  logic          pop_s;
  logic          out_valid_s;
  logic          unused_line_end_s;

  assign op_load_s      = reg2dp_op_en & (state_q == ST_IDLE);
  assign in_valid_s     = sel_src_q ? cacc2sdp_valid : sdp_mrdma2cmux_valid;
  assign in_data_s      = sel_src_q ? cacc2sdp_pd[DW-1:0] : sdp_mrdma2cmux_pd[DW-1:0];
  assign in_layer_end_s = sel_src_q ? cacc2sdp_pd[DW+1] : sdp_mrdma2cmux_pd[DW+1];
  // line_end is carried on the input bus but has no role in this block
  assign unused_line_end_s = cacc2sdp_pd[DW] ^ sdp_mrdma2cmux_pd[DW];

  assign out_valid_s = (occ_q != 2'd0);
  assign push_s      = in_valid_s & rdy_q;
  assign pop_s       = out_valid_s & sdp_cmux2dp_ready;

  always_comb begin
    occ_d = occ_q;
    case ({push_s, pop_s})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (op_load_s) state_d = ST_RUN;
        else           state_d = ST_IDLE;
      end
      ST_RUN: begin
        if (push_s && in_layer_end_s) state_d = ST_DRAIN;
        else                          state_d = ST_RUN;
      end
      ST_DRAIN: begin
        // done lines up with the first IDLE cycle after the last pop
        if (occ_d == 2'd0) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    sel_src_d = op_load_s ? reg2dp_flying_mode : sel_src_q;
    // ready is flopped from next occupancy so the output ready never reaches the input ready
    rdy_d     = (state_d == ST_RUN) & (occ_d != 2'd2);
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      state_q   <= ST_IDLE;
      sel_src_q <= 1'b0;
      occ_q     <= 2'd0;
      rdy_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_src_q <= sel_src_d;
      occ_q     <= occ_d;
      rdy_q     <= rdy_d;
      done_q    <= done_d;
    end
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      ent0_q   <= '0;
      ent1_q   <= '0;
    end else begin
      if (push_s) begin
        if (wr_ptr_q) ent1_q <= in_data_s;
        else          ent0_q <= in_data_s;
        wr_ptr_q <= ~wr_ptr_q;
      end
      if (pop_s) rd_ptr_q <= ~rd_ptr_q;
    end
  end

  assign cacc2sdp_ready       = rdy_q & sel_src_q;
  assign sdp_mrdma2cmux_ready = rdy_q & ~sel_src_q;
  assign sdp_cmux2dp_valid    = out_valid_s;
  assign sdp_cmux2dp_pd       = rd_ptr_q ? ent1_q : ent0_q;
  assign cmux_done            = done_q;

`ifdef SDP_CMUX_PERF_EN
  logic [31:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (op_load_s) begin
      stall_d = 32'h0;
    end else if ((state_q != ST_IDLE) && out_valid_s && !sdp_cmux2dp_ready &&
                 (stall_q != 32'hFFFF_FFFF)) begin
      stall_d = stall_q + 32'd1;
    end else begin
      stall_d = stall_q;
    end
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) stall_q <= 32'h0;
    else                  stall_q <= stall_d;
  end

  assign dp2reg_cmux_stall = stall_q;
`else
  assign dp2reg_cmux_stall = 32'h0;
`endif

endmodule

// File: tb/tb_nvdla_sdp_core_input_mux.sv
// Randomized bench for nvdla_sdp_core_input_mux against a queue-based behavioural model.
module tb_nvdla_sdp_core_input_mux;
  localparam int DW = 256;

  logic          clk = 1'b0;
  logic          rstn;
  logic          reg2dp_op_en, reg2dp_flying_mode;
  logic          cacc2sdp_valid, cacc2sdp_ready;
  logic [DW+1:0] cacc2sdp_pd;
  logic          sdp_mrdma2cmux_valid, sdp_mrdma2cmux_ready;
  logic [DW+1:0] sdp_mrdma2cmux_pd;
  logic          sdp_cmux2dp_valid, sdp_cmux2dp_ready;
  logic [DW-1:0] sdp_cmux2dp_pd;
  logic          cmux_done;
  logic [31:0]   dp2reg_cmux_stall;

  nvdla_sdp_core_input_mux #(.DW(DW)) dut (
    .nvdla_core_clk      (clk),
    .nvdla_core_rstn     (rstn),
    .reg2dp_op_en        (reg2dp_op_en),
    .reg2dp_flying_mode  (reg2dp_flying_mode),
    .cacc2sdp_valid      (cacc2sdp_valid),
    .cacc2sdp_ready      (cacc2sdp_ready),
    .cacc2sdp_pd         (cacc2sdp_pd),
    .sdp_mrdma2cmux_valid(sdp_mrdma2cmux_valid),
    .sdp_mrdma2cmux_ready(sdp_mrdma2cmux_ready),
    .sdp_mrdma2cmux_pd   (sdp_mrdma2cmux_pd),
    .sdp_cmux2dp_valid   (sdp_cmux2dp_valid),
    .sdp_cmux2dp_ready   (sdp_cmux2dp_ready),
    .sdp_cmux2dp_pd      (sdp_cmux2dp_pd),
    .cmux_done           (cmux_done),
    .dp2reg_cmux_stall   (dp2reg_cmux_stall)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model: layer activity, end-seen flag, in-flight beats in order
  bit            m_active, m_seen_end, m_src, m_done;
  logic [31:0]   m_stall;
  logic [DW-1:0] mq[$];

  // stimulus state
  logic [DW+1:0] pend[$];
  bit            src_hold, cur_mode, want_load, dense, layer_over;
  int            rdy_style, lcyc, out_cnt, obs_done;

  task automatic check_eq(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [DW+1:0] junk();
    logic [DW+1:0] v;
    v = {2'($urandom_range(0, 3)), {8{$urandom}}};
    return v;
  endfunction

  task automatic model_clear();
    m_active = 1'b0; m_seen_end = 1'b0; m_src = 1'b0; m_done = 1'b0;
    m_stall = 32'h0; mq.delete(); pend.delete(); src_hold = 1'b0; want_load = 1'b0;
  endtask

  task automatic step();
    logic          exp_rdy, exp_vld, acc, pop;
    logic [31:0]   exp_stall;
    logic [DW+1:0] beat, acc_pd;
    @(negedge clk);
    exp_rdy = m_active && !m_seen_end && (mq.size() < 2);
    exp_vld = (mq.size() != 0);
`ifdef SDP_CMUX_PERF_EN
    exp_stall = m_stall;
`else
    exp_stall = 32'h0;
`endif
    check_eq("cacc_ready", DW'(cacc2sdp_ready), DW'(exp_rdy && m_src));
    check_eq("mrdma_ready", DW'(sdp_mrdma2cmux_ready), DW'(exp_rdy && !m_src));
    check_eq("out_valid", DW'(sdp_cmux2dp_valid), DW'(exp_vld));
    if (exp_vld) check_eq("out_pd", sdp_cmux2dp_pd, mq[0]);
    check_eq("done", DW'(cmux_done), DW'(m_done));
    check_eq("stall", DW'(dp2reg_cmux_stall), DW'(exp_stall));
    obs_done += int'(cmux_done);

    case (rdy_style)
      0:       sdp_cmux2dp_ready = 1'b1;
      1:       sdp_cmux2dp_ready = (lcyc % 2 == 0);
      2:       sdp_cmux2dp_ready = 1'($urandom_range(0, 1));
      3:       sdp_cmux2dp_ready = !(lcyc >= 6 && lcyc < 16);
      default: sdp_cmux2dp_ready = 1'b0;
    endcase
    if (!src_hold && pend.size() != 0 && (dense || $urandom_range(0, 2) != 0)) src_hold = 1'b1;
    beat = src_hold ? pend[0] : junk();
    if (cur_mode) begin
      cacc2sdp_valid = src_hold; cacc2sdp_pd = beat;
      sdp_mrdma2cmux_valid = 1'($urandom_range(0, 1)); sdp_mrdma2cmux_pd = junk();
    end else begin
      sdp_mrdma2cmux_valid = src_hold; sdp_mrdma2cmux_pd = beat;
      cacc2sdp_valid = 1'($urandom_range(0, 1)); cacc2sdp_pd = junk();
    end
    reg2dp_op_en = want_load;

    acc    = exp_rdy && (m_src ? cacc2sdp_valid : sdp_mrdma2cmux_valid);
    acc_pd = m_src ? cacc2sdp_pd : sdp_mrdma2cmux_pd;
    pop    = exp_vld && sdp_cmux2dp_ready;
    if (m_active && exp_vld && !sdp_cmux2dp_ready && m_stall != 32'hFFFF_FFFF) m_stall++;
    if (pop) begin
      void'(mq.pop_front());
      out_cnt++;
    end
    if (acc) begin
      mq.push_back(acc_pd[DW-1:0]);
      if (acc_pd[DW+1]) m_seen_end = 1'b1;
      void'(pend.pop_front());
      src_hold = 1'b0;
    end
    m_done = 1'b0;
    if (m_active) begin
      if (m_seen_end && mq.size() == 0) begin
        m_done = 1'b1; m_active = 1'b0; m_seen_end = 1'b0; layer_over = 1'b1;
      end
    end else if (reg2dp_op_en) begin
      m_active = 1'b1; m_src = reg2dp_flying_mode; m_stall = 32'h0; want_load = 1'b0;
    end
    lcyc++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    model_clear();
    cacc2sdp_valid = 1'b0; sdp_mrdma2cmux_valid = 1'b0; reg2dp_op_en = 1'b0;
    @(negedge clk);
    check_eq("rst_valid", DW'(sdp_cmux2dp_valid), DW'(0));
    check_eq("rst_done", DW'(cmux_done), DW'(0));
    check_eq("rst_stall", DW'(dp2reg_cmux_stall), DW'(0));
    check_eq("rst_ready", DW'({cacc2sdp_ready, sdp_mrdma2cmux_ready}), DW'(0));
    rstn = 1'b1;
  endtask

  task automatic run_layer(input bit mode, input int n, input int style, input bit dn,
                           input bit idx_data, input int toggle_at, input bit abort_fill);
    logic [DW-1:0] d;
    pend.delete();
    for (int i = 0; i < n; i++) begin
      d = idx_data ? DW'(i) : {8{$urandom}};
      pend.push_back({(i == n - 1), 1'($urandom_range(0, 1)), d});
    end
    cur_mode = mode; reg2dp_flying_mode = mode; want_load = 1'b1;
    rdy_style = style; dense = dn; lcyc = 0; out_cnt = 0; obs_done = 0; layer_over = 1'b0;
    while (!layer_over && lcyc < 600) begin
      if (lcyc == toggle_at) reg2dp_flying_mode = ~mode;
      step();
      if (abort_fill && mq.size() == 2) break;
    end
    if (abort_fill) begin
      check_eq("fill_two", DW'(mq.size()), DW'(2));
      do_reset();
    end else begin
      check_eq("timeout", DW'(layer_over), DW'(1));
      step();
      check_eq("beats_out", DW'(out_cnt), DW'(n));
      check_eq("done_count", DW'(obs_done), DW'(1));
    end
  endtask

  initial begin
    rstn = 1'b0;
    reg2dp_op_en = 1'b0; reg2dp_flying_mode = 1'b0;
    cacc2sdp_valid = 1'b0; cacc2sdp_pd = '0;
    sdp_mrdma2cmux_valid = 1'b0; sdp_mrdma2cmux_pd = '0;
    sdp_cmux2dp_ready = 1'b0;
    model_clear();
    repeat (3) @(negedge clk);
    check_eq("init_valid", DW'(sdp_cmux2dp_valid), DW'(0));
    check_eq("init_pd", sdp_cmux2dp_pd, DW'(0));
    check_eq("init_done", DW'(cmux_done), DW'(0));
    check_eq("init_stall", DW'(dp2reg_cmux_stall), DW'(0));
    check_eq("init_ready", DW'({cacc2sdp_ready, sdp_mrdma2cmux_ready}), DW'(0));
    rstn = 1'b1;

    run_layer(1'b0, 8, 0, 1'b1, 1'b1, -1, 1'b0);   // MRDMA, full rate, data = index
    run_layer(1'b1, 4, 1, 1'b1, 1'b0, -1, 1'b0);   // CACC, output ready toggling
    run_layer(1'b0, 10, 3, 1'b1, 1'b0, -1, 1'b0);  // 10-cycle output stall mid-stream
    run_layer(1'b0, 9, 2, 1'b0, 1'b0, 4, 1'b0);    // flying_mode flipped mid-layer
    run_layer(1'b1, 3, 2, 1'b1, 1'b0, -1, 1'b0);   // next layer picks up the new mode
    run_layer(1'b1, 6, 4, 1'b1, 1'b0, -1, 1'b1);   // reset with two beats buffered
    run_layer(1'b0, 5, 0, 1'b1, 1'b0, -1, 1'b0);   // clean layer after reset
    run_layer(1'b1, 1, 0, 1'b1, 1'b0, -1, 1'b0);   // single-beat layer
    for (int k = 0; k < 20; k++) begin
      run_layer(1'($urandom_range(0, 1)), $urandom_range(1, 12), $urandom_range(0, 3),
                1'($urandom_range(0, 1)), 1'b0, -1, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
